gf16_const_mul: RTL and testbench

//  Registered GF(2^4) multiplier for the Piccolo F-function diffusion layer.
//  - Multiplies each 4-bit lane of an input word by one 4-bit coefficient m in GF(2^4).
//  - Field polynomial is x^4+x+1.
//  - Sixteen instances, with coefficients taken from the circulant rows {2,3,1,1}, feed the

---
 rtl/gf16_const_mul_if.sv | 19 +
 rtl/gf16_const_mul.sv | 76 +++++++
 tb/tb_gf16_const_mul.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/gf16_const_mul_if.sv
// Operand/result bundle for gf16_const_mul; coef_err exists only when GF16_COEF_CHK_EN is defined.
interface gf16_const_mul_if #(
  parameter int unsigned LANES = 4
);
  logic                 in_valid;
  logic [3:0]           m;
  logic [4*LANES-1:0]   a;
  logic                 out_valid;
  logic [4*LANES-1:0]   q;
`ifdef GF16_COEF_CHK_EN
  logic                 coef_err;

  modport master (output in_valid, m, a, input out_valid, q, coef_err);
  modport slave  (input in_valid, m, a, output out_valid, q, coef_err);
`else
  modport master (output in_valid, m, a, input out_valid, q);
  modport slave  (input in_valid, m, a, output out_valid, q);
`endif
endinterface

// File: rtl/gf16_const_mul.sv
// Registered GF(2^4) lane-wise constant multiplier (x^4 + POLY reduction), 1-cycle latency.
// Optional coefficient range flag coef_err is built when GF16_COEF_CHK_EN is defined.
module gf16_const_mul #(
  parameter int unsigned LANES = 4,
  parameter logic [3:0]  POLY  = 4'h3
) (
  input  logic              clk,
  input  logic              rst,
  gf16_const_mul_if.slave   bus
);

  function automatic logic [3:0] gf_mul(input logic [3:0] c, input logic [3:0] x);
    logic [3:0] p;
    logic [3:0] t;
    p = '0;
    t = x;
    for (int unsigned k = 0; k < 4; k++) begin
      if (c[k]) p = p ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? POLY : 4'h0);
    end
    return p;
  endfunction

  logic [4*LANES-1:0] q_d, q_q;
  logic               out_valid_d, out_valid_q;
  logic [4*LANES-1:0] prod;

  always_comb begin
    prod = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      prod[4*i +: 4] = gf_mul(bus.m, bus.a[4*i +: 4]);
    end
  end

  // q holds its last product while idle; only out_valid drops.
  always_comb begin
    q_d         = q_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      q_d         = prod;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      q_q         <= q_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.out_valid = out_valid_q;

`ifdef GF16_COEF_CHK_EN
  logic coef_err_d, coef_err_q;

  always_comb begin
    coef_err_d = 1'b0;
    if (bus.in_valid) begin
      coef_err_d = !(bus.m == 4'd1 || bus.m == 4'd2 || bus.m == 4'd3);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) coef_err_q <= 1'b0;
    else     coef_err_q <= coef_err_d;
  end

  assign bus.coef_err = coef_err_q;
`endif

endmodule

// File: tb/tb_gf16_const_mul.sv
// Directed-vector bench for gf16_const_mul (LANES=4, x^4+x+1); coef_err checks need GF16_COEF_CHK_EN.
module tb_gf16_const_mul;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  gf16_const_mul_if #(.LANES(4)) bus ();

  gf16_const_mul #(.LANES(4), .POLY(4'h3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] mm, input logic [15:0] aa);
    bus.in_valid = v;
    bus.m        = mm;
    bus.a        = aa;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 4'h2, 16'hFFFF);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.q !== 16'h0000) begin
        errors++;
        $display("FAIL reset_q cycle %0d: got %h expected 0000", i, bus.q);
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_valid cycle %0d: got %b expected 0", i, bus.out_valid);
      end
`ifdef GF16_COEF_CHK_EN
      checks++;
      if (bus.coef_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_coef_err cycle %0d: got %b expected 0", i, bus.coef_err);
      end
`endif
    end
    rst = 1'b0;
    drive(1'b0, 4'h0, 16'h0000);
    step();
  endtask

  task automatic test_mul2();
    drive(1'b1, 4'h2, 16'h8421);
    step();
    drive(1'b0, 4'h0, 16'h0000);
    checks++;
    if (bus.q !== 16'h3842) begin
      errors++;
      $display("FAIL mul2_q: got %h expected 3842", bus.q);
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mul2_valid: got %b expected 1", bus.out_valid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'h3, 16'h9999);
    step();
    checks++;
    if (bus.q !== 16'h8888 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_mul3: got q=%h v=%b expected q=8888 v=1", bus.q, bus.out_valid);
    end
    drive(1'b1, 4'h1, 16'hABCD);
    step();
    checks++;
    if (bus.q !== 16'hABCD || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_mul1: got q=%h v=%b expected q=abcd v=1", bus.q, bus.out_valid);
    end
    drive(1'b0, 4'h0, 16'h0000);
    step();
  endtask

  task automatic test_full_and_zero();
    drive(1'b1, 4'hF, 16'hFFFF);
    step();
    checks++;
    if (bus.q !== 16'hAAAA || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mulF: got q=%h v=%b expected q=aaaa v=1", bus.q, bus.out_valid);
    end
    drive(1'b0, 4'h7, 16'h5555);
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.q !== 16'hAAAA) begin
      errors++;
      $display("FAIL idle_hold_q: got %h expected aaaa", bus.q);
    end
    drive(1'b1, 4'h0, 16'h1234);
    step();
    checks++;
    if (bus.q !== 16'h0000 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mul0: got q=%h v=%b expected q=0000 v=1", bus.q, bus.out_valid);
    end
    drive(1'b0, 4'h0, 16'h0000);
    step();
  endtask

  task automatic test_reset_priority();
    drive(1'b1, 4'h1, 16'hABCD);
    step();
    checks++;
    if (bus.q !== 16'hABCD) begin
      errors++;
      $display("FAIL prio_setup_q: got %h expected abcd", bus.q);
    end
    rst = 1'b1;
    drive(1'b1, 4'h2, 16'h0001);
    step();
    rst = 1'b0;
    drive(1'b0, 4'h0, 16'h0000);
    checks++;
    if (bus.q !== 16'h0000) begin
      errors++;
      $display("FAIL prio_q: got %h expected 0000", bus.q);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL prio_valid: got %b expected 0", bus.out_valid);
    end
    step();
  endtask

  task automatic test_coef_chk();
`ifdef GF16_COEF_CHK_EN
    drive(1'b1, 4'h4, 16'h1234);
    step();
    checks++;
    if (bus.coef_err !== 1'b1) begin
      errors++;
      $display("FAIL coef4_err: got %b expected 1", bus.coef_err);
    end
    checks++;
    if (bus.q !== 16'h48C3) begin
      errors++;
      $display("FAIL coef4_q: got %h expected 48c3", bus.q);
    end
    drive(1'b1, 4'h2, 16'h1234);
    step();
    checks++;
    if (bus.coef_err !== 1'b0 || bus.q !== 16'h2468) begin
      errors++;
      $display("FAIL coef2: got err=%b q=%h expected err=0 q=2468", bus.coef_err, bus.q);
    end
    drive(1'b1, 4'h4, 16'h0000);
    step();
    drive(1'b0, 4'h4, 16'h0000);
    step();
    checks++;
    if (bus.coef_err !== 1'b0) begin
      errors++;
      $display("FAIL coef_idle_err: got %b expected 0", bus.coef_err);
    end
`else
    drive(1'b1, 4'h4, 16'h1234);
    step();
    checks++;
    if (bus.q !== 16'h48C3) begin
      errors++;
      $display("FAIL mul4_q: got %h expected 48c3", bus.q);
    end
    drive(1'b0, 4'h0, 16'h0000);
    step();
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(1'b0, 4'h0, 16'h0000);
    test_reset();
    test_mul2();
    test_back_to_back();
    test_full_and_zero();
    test_reset_priority();
    test_coef_chk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
